// File: rtl/trap_controller.sv
// Sequences exceptions and MRET from execute into CSR update strobes, then redirects fetch.
// Latency: strobe at +1, redirect at +2, next event accepted at +3+DRAIN_CYCLES; stall holds upstream.
module trap_controller #(
    parameter int DRAIN_CYCLES = 2,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_instr,
    input  logic               ex_ecall,
    input  logic               ex_ebreak,
    input  logic               ex_mret,
    input  logic               ex_misaligned,
    input  logic               ex_misaligned_store,
    input  logic [31:0]        ex_store_value,
    input  logic [14:0]        ex_mem_addr,
    input  logic [4:0]         ex_rd_addr,
    input  logic [31:0]        mtvec_val,
    input  logic [31:0]        mepc_val,
    output logic               csr_ecall,
    output logic               csr_ebreak,
    output logic               csr_mret,
    output logic               csr_misaligned,
    output logic               csr_misaligned_store,
    output logic [31:0]        csr_pc,
    output logic [31:0]        csr_in,
    output logic [31:0]        csr_store_value,
    output logic [14:0]        csr_mem_addr,
    output logic [4:0]         csr_rd_addr,
    output logic               stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               busy,
    output logic [COUNT_W-1:0] trap_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_REDIRECT,
        S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        K_MISAL,
        K_ECALL,
        K_EBREAK,
        K_MRET
    } kind_t;

    state_t             r_state;
    state_t             w_next;
    kind_t              r_kind;
    kind_t              w_kind;
    logic               w_event;
    logic               w_take;
    logic [DW-1:0]      r_drain;
    logic [COUNT_W-1:0] r_trap_count;
    logic               r_csr_ecall;
    logic               r_csr_ebreak;
    logic               r_csr_mret;
    logic               r_csr_misaligned;
    logic               r_misal_store;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [31:0]        r_store_value;
    logic [14:0]        r_mem_addr;
    logic [4:0]         r_rd_addr;
    logic [31:0]        w_trap_vec;

    assign w_event = ex_valid & (ex_misaligned | ex_ecall | ex_ebreak | ex_mret);
    assign w_take  = (r_state == S_IDLE) && w_event;
    // Exceptions always go to the mtvec base; the low mode bits are masked off.
    assign w_trap_vec = mtvec_val & 32'hFFFF_FFFC;

    always_comb begin
        w_kind = K_MRET;
        if (ex_misaligned) begin
            w_kind = K_MISAL;
        end else if (ex_ecall) begin
            w_kind = K_ECALL;
        end else if (ex_ebreak) begin
            w_kind = K_EBREAK;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_event) w_next = S_COMMIT;
            S_COMMIT:   w_next = S_REDIRECT;
            S_REDIRECT: w_next = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
            S_DRAIN:    if (r_drain == '0) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_kind           <= K_MISAL;
            r_drain          <= '0;
            r_trap_count     <= '0;
            r_csr_ecall      <= 1'b0;
            r_csr_ebreak     <= 1'b0;
            r_csr_mret       <= 1'b0;
            r_csr_misaligned <= 1'b0;
            r_misal_store    <= 1'b0;
            r_pc             <= '0;
            r_instr          <= '0;
            r_store_value    <= '0;
            r_mem_addr       <= '0;
            r_rd_addr        <= '0;
        end else begin
            r_state          <= w_next;
            r_csr_misaligned <= w_take && (w_kind == K_MISAL);
            r_csr_ecall      <= w_take && (w_kind == K_ECALL);
            r_csr_ebreak     <= w_take && (w_kind == K_EBREAK);
            r_csr_mret       <= w_take && (w_kind == K_MRET);
            if (w_take) begin
                r_kind        <= w_kind;
                r_misal_store <= ex_misaligned & ex_misaligned_store;
                r_pc          <= ex_pc;
                r_instr       <= ex_instr;
                r_store_value <= ex_store_value;
                r_mem_addr    <= ex_mem_addr;
                r_rd_addr     <= ex_rd_addr;
            end
            if ((r_state == S_COMMIT) && (r_kind != K_MRET) && !(&r_trap_count)) begin
                r_trap_count <= r_trap_count + COUNT_W'(1);
            end
            if (r_state == S_REDIRECT) begin
                r_drain <= DW'(DRAIN_CYCLES - 1);
            end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
                r_drain <= r_drain - DW'(1);
            end
        end
    end

    // Redirect is suppressed while reset is held so an aborted sequence never steers fetch.
    always_comb begin
        stall          = 1'b1;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            S_IDLE:   stall = w_event;
            S_COMMIT: flush = 1'b1;
            S_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = !rst;
                if (!rst) begin
                    redirect_pc = (r_kind == K_MRET) ? mepc_val : w_trap_vec;
                end
            end
            default: ;
        endcase
    end

    assign busy                 = (r_state != S_IDLE);
    assign csr_ecall            = r_csr_ecall;
    assign csr_ebreak           = r_csr_ebreak;
    assign csr_mret             = r_csr_mret;
    assign csr_misaligned       = r_csr_misaligned;
    assign csr_misaligned_store = r_misal_store;
    assign csr_pc               = r_pc;
    assign csr_in               = r_instr;
    assign csr_store_value      = r_store_value;
    assign csr_mem_addr         = r_mem_addr;
    assign csr_rd_addr          = r_rd_addr;
    assign trap_count           = r_trap_count;

endmodule
